// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared states, CRC constants and default chain lengths for the config loader
package fpga_cfg_pkg;

  // FSM encoding shared by the loader and anything that decodes its state.
  typedef logic [2:0] cfg_state_t;

  localparam cfg_state_t ST_IDLE      = 3'd0;
  localparam cfg_state_t ST_LOAD_CLB  = 3'd1;
  localparam cfg_state_t ST_LOAD_CONN = 3'd2;
  localparam cfg_state_t ST_CHECK     = 3'd3;
  localparam cfg_state_t ST_DONE      = 3'd4;

  // CRC-16-CCITT, processed MSB first.
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Default scan chain lengths in bits.
  localparam int CLB_BITS_DEFAULT  = 4096;
  localparam int CONN_BITS_DEFAULT = 8192;

endpackage

// File: rtl/fpga_cfg_crc16.sv
// rtl/fpga_cfg_crc16.sv - bit-serial CRC-16-CCITT accumulator, built only with FPGA_CFG_CRC_EN
`ifdef FPGA_CFG_CRC_EN
module fpga_cfg_crc16
  import fpga_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // One shift of the CCITT LFSR per enabled bit; clear reseeds for a new load.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC16_INIT;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ bit_in}} & CRC16_POLY);
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC16_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - byte stream to CLB/connection scan chain loader; optional CRC check via FPGA_CFG_CRC_EN
module fpga_config_loader
  import fpga_cfg_pkg::*;
#(
  // Each length must lie in 1..65535 (16-bit bit counter).
  parameter int CLB_BITS  = CLB_BITS_DEFAULT,
  parameter int CONN_BITS = CONN_BITS_DEFAULT
) (
  input  logic       scan_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       clb_scan_in,
  output logic       clb_scan_en,
  output logic       conn_scan_in,
  output logic       conn_scan_en,
  output logic       busy,
  output logic       done,
  output logic       crc_err
);

  localparam logic [15:0] CLB_LEN  = 16'(CLB_BITS);
  localparam logic [15:0] CONN_LEN = 16'(CONN_BITS);

  cfg_state_t  state_q, state_d;
  logic [7:0]  sr_q, sr_d;              // byte being serialised, next bit in [7]
  logic [3:0]  sr_cnt_q, sr_cnt_d;      // bits still to present from sr_q
  logic [15:0] bits_left_q, bits_left_d; // bits still to shift in the current section
  logic        clb_in_q, clb_in_d;
  logic        clb_en_q, clb_en_d;
  logic        conn_in_q, conn_in_d;
  logic        conn_en_q, conn_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        in_load;
  logic        need_byte;
  logic        accept;
  logic        start_load;
  logic        pres;
  logic        pres_bit;

`ifdef FPGA_CFG_CRC_EN
  logic [7:0]  crc_hi_q, crc_hi_d;
  logic        crc_hi_seen_q, crc_hi_seen_d;
  logic        crc_err_q, crc_err_d;
  logic [15:0] crc_val;
`endif

  // Byte handshake: a new byte is taken only when the shift register drains this
  // cycle and the section still needs bits beyond those already buffered.
  always_comb begin
    in_load   = (state_q == ST_LOAD_CLB) || (state_q == ST_LOAD_CONN);
    need_byte = bits_left_q > {12'd0, sr_cnt_q};
    cfg_ready = in_load && (sr_cnt_q <= 4'd1) && need_byte;
`ifdef FPGA_CFG_CRC_EN
    if (state_q == ST_CHECK) begin
      cfg_ready = 1'b1;
    end
`endif
  end

  assign accept     = cfg_valid && cfg_ready;
  assign start_load = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Serialiser: choose the bit presented this cycle and refill the shift register.
  always_comb begin
    pres     = 1'b0;
    pres_bit = 1'b0;
    sr_d     = sr_q;
    sr_cnt_d = sr_cnt_q;
    if (in_load) begin
      if (sr_cnt_q != 4'd0) begin
        pres     = 1'b1;
        pres_bit = sr_q[7];
        if (accept) begin
          sr_d     = cfg_data;
          sr_cnt_d = 4'd8;
        end else begin
          sr_d     = {sr_q[6:0], 1'b0};
          sr_cnt_d = sr_cnt_q - 4'd1;
        end
      end else if (accept) begin
        pres     = 1'b1;
        pres_bit = cfg_data[7];
        sr_d     = {cfg_data[6:0], 1'b0};
        sr_cnt_d = 4'd7;
      end
      // Last bit of a section: whatever is left of the byte is padding.
      if (pres && (bits_left_q == 16'd1)) begin
        sr_cnt_d = 4'd0;
      end
    end
    if (start_load) begin
      sr_cnt_d = 4'd0;
    end
  end

  // Sequencer: route presented bits to the active chain and walk the sections.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    busy_d      = busy_q;
    done_d      = done_q;
    clb_in_d    = clb_in_q;
    clb_en_d    = 1'b0;
    conn_in_d   = conn_in_q;
    conn_en_d   = 1'b0;
`ifdef FPGA_CFG_CRC_EN
    crc_hi_d      = crc_hi_q;
    crc_hi_seen_d = crc_hi_seen_q;
    crc_err_d     = crc_err_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_LOAD_CLB;
          bits_left_d = CLB_LEN;
          busy_d      = 1'b1;
          done_d      = 1'b0;
`ifdef FPGA_CFG_CRC_EN
          crc_err_d   = 1'b0;
`endif
        end
      end
      ST_LOAD_CLB: begin
        if (pres) begin
          clb_en_d    = 1'b1;
          clb_in_d    = pres_bit;
          bits_left_d = bits_left_q - 16'd1;
          if (bits_left_q == 16'd1) begin
            state_d     = ST_LOAD_CONN;
            bits_left_d = CONN_LEN;
          end
        end
      end
      ST_LOAD_CONN: begin
        if (pres) begin
          conn_en_d   = 1'b1;
          conn_in_d   = pres_bit;
          bits_left_d = bits_left_q - 16'd1;
          if (bits_left_q == 16'd1) begin
`ifdef FPGA_CFG_CRC_EN
            state_d       = ST_CHECK;
            crc_hi_seen_d = 1'b0;
`else
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end
        end
      end
      ST_CHECK: begin
`ifdef FPGA_CFG_CRC_EN
        // Trailing CRC arrives high byte first; compare on the low byte.
        if (accept) begin
          if (!crc_hi_seen_q) begin
            crc_hi_d      = cfg_data;
            crc_hi_seen_d = 1'b1;
          end else begin
            state_d   = ST_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            crc_err_d = (crc_val != {crc_hi_q, cfg_data});
          end
        end
`else
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered chain outputs; reset kills any load in flight.
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= 8'd0;
      sr_cnt_q    <= 4'd0;
      bits_left_q <= 16'd0;
      clb_in_q    <= 1'b0;
      clb_en_q    <= 1'b0;
      conn_in_q   <= 1'b0;
      conn_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      sr_cnt_q    <= sr_cnt_d;
      bits_left_q <= bits_left_d;
      clb_in_q    <= clb_in_d;
      clb_en_q    <= clb_en_d;
      conn_in_q   <= conn_in_d;
      conn_en_q   <= conn_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef FPGA_CFG_CRC_EN
  // CRC trailer capture and sticky mismatch flag.
  always_ff @(posedge scan_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_hi_q      <= 8'd0;
      crc_hi_seen_q <= 1'b0;
      crc_err_q     <= 1'b0;
    end else begin
      crc_hi_q      <= crc_hi_d;
      crc_hi_seen_q <= crc_hi_seen_d;
      crc_err_q     <= crc_err_d;
    end
  end

  fpga_cfg_crc16 u_crc16 (
    .clk    (scan_clk),
    .rst_n  (rst_n),
    .clear  (start_load),
    .en     (pres),
    .bit_in (pres_bit),
    .crc    (crc_val)
  );

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign clb_scan_in  = clb_in_q;
  assign clb_scan_en  = clb_en_q;
  assign conn_scan_in = conn_in_q;
  assign conn_scan_en = conn_en_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - self-checking bench for fpga_config_loader (12-bit CLB, 4-bit connection chain)
module tb_fpga_config_loader;

  localparam int CLB_N     = 12;
  localparam int CONN_N    = 4;
  localparam int CLB_BYTES = (CLB_N + 7) / 8;
`ifdef FPGA_CFG_CRC_EN
  localparam int CRC_TAIL = 2;
`else
  localparam int CRC_TAIL = 0;
`endif

  logic       scan_clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       clb_scan_in;
  logic       clb_scan_en;
  logic       conn_scan_in;
  logic       conn_scan_en;
  logic       busy;
  logic       done;
  logic       crc_err;
  logic [7:0] outs;

  fpga_config_loader #(.CLB_BITS(CLB_N), .CONN_BITS(CONN_N)) dut (
    .scan_clk     (scan_clk),
    .rst_n        (rst_n),
    .start        (start),
    .cfg_data     (cfg_data),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .clb_scan_in  (clb_scan_in),
    .clb_scan_en  (clb_scan_en),
    .conn_scan_in (conn_scan_in),
    .conn_scan_en (conn_scan_en),
    .busy         (busy),
    .done         (done),
    .crc_err      (crc_err)
  );

  assign outs = {cfg_ready, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en, busy, done, crc_err};

  always #5 scan_clk = ~scan_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Chain monitor: cumulative pulse counts and bit history, sampled mid-cycle.
  int          cyc = 0;
  int          clb_tot = 0;
  int          conn_tot = 0;
  int          busy_tot = 0;
  int          both_tot = 0;
  int          last_conn_cyc = 0;
  int          done_rise_cyc = 0;
  logic        done_prev = 1'b0;
  logic [63:0] clb_hist = '0;
  logic [63:0] conn_hist = '0;

  always @(negedge scan_clk) begin
    cyc <= cyc + 1;
    if (clb_scan_en) begin
      clb_tot  <= clb_tot + 1;
      clb_hist <= {clb_hist[62:0], clb_scan_in};
    end
    if (conn_scan_en) begin
      conn_tot      <= conn_tot + 1;
      conn_hist     <= {conn_hist[62:0], conn_scan_in};
      last_conn_cyc <= cyc;
    end
    if (clb_scan_en && conn_scan_en) both_tot <= both_tot + 1;
    if (busy) busy_tot <= busy_tot + 1;
    done_prev <= done;
    if (done && !done_prev) done_rise_cyc <= cyc;
  end

  // Reference model: the byte stream as a flat MSB-first bit sequence, each
  // section starting on a fresh byte.
  logic [7:0] tx[$];

  function automatic logic [63:0] sect_bits(input int first_byte, input int n);
    logic [63:0] r;
    logic [7:0]  b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      b = tx[first_byte + i / 8];
      r = {r[62:0], b[7 - (i % 8)]};
    end
    return r;
  endfunction

  function automatic logic [63:0] mask(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

`ifdef FPGA_CFG_CRC_EN
  function automatic logic [15:0] crc16(input logic [63:0] bits, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction
`endif

  task automatic build_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit flip);
`ifdef FPGA_CFG_CRC_EN
    logic [15:0] c;
`endif
    tx = {b0, b1, b2};
`ifdef FPGA_CFG_CRC_EN
    c = crc16((sect_bits(0, CLB_N) << CONN_N) | sect_bits(CLB_BYTES, CONN_N), CLB_N + CONN_N);
    tx.push_back(c[15:8]);
    tx.push_back(c[7:0]);
`endif
    if (flip) tx[0] = tx[0] ^ 8'h80;
  endtask

  // Feed tx after a start pulse. Optional: withhold byte gap_idx for gap_len
  // ready-high cycles, pulse start once inside CLB (1) or CONN (2), or pull
  // reset after abort_clb CLB pulses.
  task automatic run_load(input int gap_idx, input int gap_len, input int start_mode,
                          input int abort_clb, output int acc);
    int idx = 0;
    int gap_left = gap_len;
    int budget = 0;
    int clb0 = clb_tot;
    int conn0 = conn_tot;
    bit pulsed = 1'b0;
    start = 1'b1;
    cfg_valid = 1'b0;
    @(negedge scan_clk); #1;
    start = 1'b0;
    chk("start_clears_done", done, 1'b0);
    chk("start_sets_busy", busy, 1'b1);
    forever begin
      if (abort_clb > 0 && (clb_tot - clb0) >= abort_clb) begin
        rst_n = 1'b0;
        break;
      end
      if (done) break;
      if (budget > 300) begin
        chk("load_done_within_budget", done, 1'b1);
        break;
      end
      start = 1'b0;
      if (!pulsed && ((start_mode == 1 && clb_tot > clb0) || (start_mode == 2 && conn_tot > conn0))) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (idx < tx.size()) begin
        cfg_data = tx[idx];
        if (idx == gap_idx && gap_left > 0) begin
          cfg_valid = 1'b0;
          if (cfg_ready) gap_left--;
        end else begin
          cfg_valid = 1'b1;
          if (cfg_ready) idx++;
        end
      end else begin
        cfg_valid = 1'b0;
      end
      @(negedge scan_clk); #1;
      budget++;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    acc = idx;
  endtask

  task automatic check_load(input string tag, input int gap_idx, input int gap_len,
                            input int exp_gap, input int start_mode, input logic exp_crc_err);
    int clb0 = clb_tot;
    int conn0 = conn_tot;
    int busy0 = busy_tot;
    int both0 = both_tot;
    int acc;
    logic [63:0] exp_clb  = sect_bits(0, CLB_N);
    logic [63:0] exp_conn = sect_bits(CLB_BYTES, CONN_N);
    run_load(gap_idx, gap_len, start_mode, 0, acc);
    chk({tag, "_clb_pulses"}, clb_tot - clb0, CLB_N);
    chk({tag, "_conn_pulses"}, conn_tot - conn0, CONN_N);
    chk({tag, "_clb_bits"}, clb_hist & mask(CLB_N), exp_clb);
    chk({tag, "_conn_bits"}, conn_hist & mask(CONN_N), exp_conn);
    chk({tag, "_bytes_taken"}, acc, tx.size());
    chk({tag, "_busy_cycles"}, busy_tot - busy0, CLB_N + CONN_N + exp_gap + CRC_TAIL);
    chk({tag, "_done_edge"}, done_rise_cyc - last_conn_cyc, CRC_TAIL);
    chk({tag, "_enables_exclusive"}, both_tot - both0, 0);
    chk({tag, "_end_flags"}, {cfg_ready, busy, done, crc_err}, {3'b001, exp_crc_err});
  endtask

  initial begin
    int clb0;
    int conn0;
    int acc;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'hA5;
    repeat (3) @(negedge scan_clk); #1;
    chk("reset_outputs_zero", outs, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge scan_clk); #1;
    chk("idle_ready_low", cfg_ready, 1'b0);
    chk("idle_not_busy", busy, 1'b0);

    // Trailing bits of F0 and 80 must never reach a chain.
    build_tx(8'hFF, 8'hF0, 8'h80, 1'b0);
    check_load("tail_discard", -1, 0, 0, 0, 1'b0);

    // Underrun at the CLB/CONN boundary: every withheld cycle is a hole.
    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check_load("gap_boundary", 2, 5, 5, 0, 1'b0);

    // Underrun mid-section: ready rises while the previous byte's last bit is
    // still going out, so the first withheld cycle still shifts.
    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check_load("gap_mid_section", 1, 5, 4, 0, 1'b0);

    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check_load("start_in_clb", -1, 0, 0, 1, 1'b0);

    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check_load("start_in_conn", -1, 0, 0, 2, 1'b0);

    // Reset after 7 CLB bits, then a fresh full load.
    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    clb0  = clb_tot;
    conn0 = conn_tot;
    run_load(-1, 0, 0, 7, acc);
    #1;
    chk("abort_outputs_zero", outs, 8'h00);
    cfg_valid = 1'b1;
    start = 1'b1;
    repeat (5) @(negedge scan_clk); #1;
    start = 1'b0;
    cfg_valid = 1'b0;
    chk("abort_clb_pulses", clb_tot - clb0, 7);
    chk("abort_conn_pulses", conn_tot - conn0, 0);
    chk("abort_clb_bits", clb_hist & mask(7), sect_bits(0, 7));
    chk("abort_held_zero", outs, 8'h00);
    rst_n = 1'b1;
    @(negedge scan_clk); #1;
    check_load("reload_after_abort", -1, 0, 0, 0, 1'b0);

`ifdef FPGA_CFG_CRC_EN
    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    check_load("crc_flipped_bit", -1, 0, 0, 0, 1'b1);
    build_tx(8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    check_load("crc_good_after_bad", -1, 0, 0, 0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
